z_event_logger: RTL and testbench



---
 rtl/z_event_logger_if.sv | 10 +
 rtl/z_event_logger.sv | 91 +++++++++
 tb/tb_z_event_logger.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/z_event_logger_if.sv
// Readout bus of the event logger: show-ahead head entry plus a valid/ready handshake.
interface z_event_logger_if #(parameter int TS_W = 8);
  logic            rd_valid;
  logic            rd_ready;
  logic [1:0]      rd_code;
  logic [TS_W-1:0] rd_ts;

  modport master (output rd_valid, rd_code, rd_ts, input rd_ready);
  modport slave  (input rd_valid, rd_code, rd_ts, output rd_ready);
endinterface

// File: rtl/z_event_logger.sv
// Logs changes of the FSM output code z: per-code saturating counts, a free-running
// timestamp, and a show-ahead FIFO of (code, timestamp) drained over valid/ready.
module z_event_logger #(
  parameter int TS_W  = 8,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          z_in,
  input  logic                clr_cnt,
  z_event_logger_if.master    rd,
  output logic [CNT_W-1:0]    cnt01,
  output logic [CNT_W-1:0]    cnt10,
  output logic [CNT_W-1:0]    cnt11,
  output logic                overflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [1:0]      code;
    logic [TS_W-1:0] ts;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ;
  logic [TS_W-1:0]  ts;
  logic [1:0]       z_prev;
  logic             ev, full, not_empty, pop, push, drop;
  logic [CNT_W-1:0] cnt [1:3];

  assign ev        = (z_in != 2'b00) && (z_in != z_prev);
  assign full      = (occ == OCC_FULL);
  assign not_empty = (occ != '0);
  assign pop       = not_empty && rd.rd_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = ev && (!full || pop);
  assign drop      = ev && full && !pop;

  assign head        = mem[rd_ptr];
  assign rd.rd_valid = not_empty;
  assign rd.rd_code  = not_empty ? head.code : 2'b00;
  assign rd.rd_ts    = not_empty ? head.ts   : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ts     <= '0;
      z_prev <= 2'b00;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      ts     <= ts + TS_W'(1);
      z_prev <= z_in;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk)
    if (!reset && push) mem[wr_ptr] <= '{code: z_in, ts: ts};

  always_ff @(posedge clk) begin
    if (reset)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_cnt) overflow <= 1'b0;
  end

  for (genvar i = 1; i <= 3; i++) begin : g_cnt
    logic inc;
    assign inc = ev && (z_in == 2'(i));
    always_ff @(posedge clk) begin
      if (reset)                     cnt[i] <= '0;
      else if (clr_cnt)              cnt[i] <= inc ? CNT_W'(1) : '0;
      else if (inc && cnt[i] != '1)  cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end

  assign cnt01 = cnt[1];
  assign cnt10 = cnt[2];
  assign cnt11 = cnt[3];
endmodule

// File: tb/tb_z_event_logger.sv
// Self-checking bench for z_event_logger: directed table, corner sequences, random vs model.
module tb_z_event_logger;
  localparam int TS_W  = 8;
  localparam int CNT_W = 8;
  localparam int DEPTH = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       z_in = 2'b00;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] cnt01, cnt10, cnt11;
  logic             overflow;

  z_event_logger_if #(.TS_W(TS_W)) rd_if ();

  z_event_logger #(.TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .z_in(z_in), .clr_cnt(clr_cnt), .rd(rd_if),
    .cnt01(cnt01), .cnt10(cnt10), .cnt11(cnt11), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of events and plain integer counts.
  typedef struct { logic [1:0] code; int ts; } ent_t;
  ent_t       m_q[$];
  int         m_cnt [4];
  int         m_ovf;
  int         m_ts;
  logic [1:0] m_prev;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] z;
    logic       rdy;
    logic       v;
    logic [1:0] code;
    int         ts;
    int         c01, c10, c11;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic [1:0] z, input logic c, input logic r);
    bit ev, pop, full;
    reset = rst; z_in = z; clr_cnt = c; rd_if.rd_ready = r;
    if (rst) begin
      m_q.delete();
      m_cnt = '{default: 0};
      m_ovf = 0; m_ts = 0; m_prev = 2'b00;
    end else begin
      ev   = (z != 2'b00) && (z != m_prev);
      pop  = r && (m_q.size() > 0);
      full = (m_q.size() == DEPTH);
      if (pop) void'(m_q.pop_front());
      if (ev && (!full || pop)) m_q.push_back('{z, m_ts});
      if (c) begin m_cnt = '{default: 0}; m_ovf = 0; end
      if (ev) m_cnt[z] = (m_cnt[z] >= CMAX) ? CMAX : m_cnt[z] + 1;
      if (ev && full && !pop) m_ovf = 1;
      m_prev = z;
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_model(input string tag);
    bit ne;
    ne = (m_q.size() != 0);
    chk({tag, ".rd_valid"}, int'(rd_if.rd_valid), int'(ne));
    chk({tag, ".rd_code"},  int'(rd_if.rd_code),  ne ? int'(m_q[0].code) : 0);
    chk({tag, ".rd_ts"},    int'(rd_if.rd_ts),    ne ? m_q[0].ts : 0);
    chk({tag, ".cnt01"},    int'(cnt01), m_cnt[1]);
    chk({tag, ".cnt10"},    int'(cnt10), m_cnt[2]);
    chk({tag, ".cnt11"},    int'(cnt11), m_cnt[3]);
    chk({tag, ".overflow"}, int'(overflow), m_ovf);
  endtask

  task automatic chk_head(input string tag, input int code, input int ts);
    chk({tag, ".valid"}, int'(rd_if.rd_valid), 1);
    chk({tag, ".code"},  int'(rd_if.rd_code), code);
    chk({tag, ".ts"},    int'(rd_if.rd_ts), ts);
  endtask

  initial begin
    logic [1:0] zr;
    rd_if.rd_ready = 1'b0;
    tbl[0] = '{2'b00, 1'b1, 1'b0, 2'b00, 0, 0, 0, 0};
    tbl[1] = '{2'b01, 1'b1, 1'b1, 2'b01, 1, 1, 0, 0};
    tbl[2] = '{2'b01, 1'b1, 1'b0, 2'b00, 0, 1, 0, 0};
    tbl[3] = '{2'b11, 1'b1, 1'b1, 2'b11, 3, 1, 0, 1};
    tbl[4] = '{2'b00, 1'b1, 1'b0, 2'b00, 0, 1, 0, 1};
    tbl[5] = '{2'b10, 1'b1, 1'b1, 2'b10, 5, 1, 1, 1};
    tbl[6] = '{2'b00, 1'b1, 1'b0, 2'b00, 0, 1, 1, 1};
    @(posedge clk); #1;

    // Reset state, then idle input: nothing logged, ts keeps running
    cycle(1, 2'b00, 0, 0);
    chk("rst.rd_valid", int'(rd_if.rd_valid), 0);
    chk("rst.rd_code", int'(rd_if.rd_code), 0);
    chk("rst.rd_ts", int'(rd_if.rd_ts), 0);
    chk("rst.cnt01", int'(cnt01), 0);
    chk("rst.cnt10", int'(cnt10), 0);
    chk("rst.cnt11", int'(cnt11), 0);
    chk("rst.overflow", int'(overflow), 0);
    repeat (10) cycle(0, 2'b00, 0, 0);
    check_model("idle");
    cycle(0, 2'b01, 0, 0);
    chk_head("idle_ts", 1, 10);

    // Directed table: three events read out in order with rd_ready high
    cycle(1, 2'b00, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cycle(0, tbl[i].z, 0, tbl[i].rdy);
      chk($sformatf("tbl%0d.valid", i), int'(rd_if.rd_valid), int'(tbl[i].v));
      chk($sformatf("tbl%0d.code", i), int'(rd_if.rd_code), int'(tbl[i].code));
      chk($sformatf("tbl%0d.ts", i), int'(rd_if.rd_ts), tbl[i].ts);
      chk($sformatf("tbl%0d.cnt01", i), int'(cnt01), tbl[i].c01);
      chk($sformatf("tbl%0d.cnt10", i), int'(cnt10), tbl[i].c10);
      chk($sformatf("tbl%0d.cnt11", i), int'(cnt11), tbl[i].c11);
    end

    // Overfill with rd_ready low: 4 kept, 2 dropped, overflow sticky until clr_cnt
    cycle(1, 2'b00, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, (i % 2 == 0) ? 2'b01 : 2'b10, 0, 0);
    chk("ovf.overflow", int'(overflow), 1);
    chk("ovf.cnt01", int'(cnt01), 3);
    chk("ovf.cnt10", int'(cnt10), 3);
    for (int i = 0; i < 4; i++) begin
      chk_head($sformatf("ovf.drain%0d", i), (i % 2 == 0) ? 1 : 2, i);
      cycle(0, 2'b00, 0, 1);
    end
    chk("ovf.empty", int'(rd_if.rd_valid), 0);
    chk("ovf.sticky", int'(overflow), 1);
    cycle(0, 2'b00, 1, 0);
    chk("ovf.cleared", int'(overflow), 0);
    check_model("ovf");

    // Full FIFO with simultaneous pop and push: occupancy stays at DEPTH
    cycle(1, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, (i % 2 == 0) ? 2'b01 : 2'b10, 0, 0);
    cycle(0, 2'b01, 0, 1);
    chk("fullpp.overflow", int'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      chk_head($sformatf("fullpp.drain%0d", i), (i % 2 == 0) ? 2 : 1, i + 1);
      cycle(0, 2'b00, 0, 1);
    end
    chk("fullpp.empty", int'(rd_if.rd_valid), 0);

    // Counter saturation, then clear coinciding with an event
    cycle(1, 2'b00, 0, 0);
    for (int i = 0; i < 300; i++) begin
      cycle(0, 2'b01, 0, 1);
      cycle(0, 2'b11, 0, 1);
    end
    chk("sat.cnt01", int'(cnt01), CMAX);
    chk("sat.cnt11", int'(cnt11), CMAX);
    chk("sat.overflow", int'(overflow), 0);
    cycle(0, 2'b01, 1, 1);
    chk("clrev.cnt01", int'(cnt01), 1);
    chk("clrev.cnt11", int'(cnt11), 0);
    chk("clrev.overflow", int'(overflow), 0);

    // Drop and clear in the same cycle leave overflow set
    cycle(1, 2'b00, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, (i % 2 == 0) ? 2'b01 : 2'b10, 0, 0);
    cycle(0, 2'b01, 1, 0);
    chk("dropclr.overflow", int'(overflow), 1);
    chk("dropclr.cnt01", int'(cnt01), 1);
    check_model("dropclr");

    // Reset mid-operation discards queued entries and restarts ts
    cycle(1, 2'b00, 0, 0);
    cycle(0, 2'b01, 0, 0);
    cycle(0, 2'b10, 0, 0);
    cycle(0, 2'b01, 0, 0);
    check_model("midrst.pre");
    cycle(1, 2'b01, 0, 0);
    chk("midrst.valid", int'(rd_if.rd_valid), 0);
    chk("midrst.cnt01", int'(cnt01), 0);
    chk("midrst.cnt10", int'(cnt10), 0);
    chk("midrst.overflow", int'(overflow), 0);
    cycle(0, 2'b00, 0, 0);
    cycle(0, 2'b00, 0, 0);
    cycle(0, 2'b01, 0, 0);
    chk_head("midrst.post", 1, 2);

    // Random traffic against the model
    cycle(1, 2'b00, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      zr = 2'($urandom_range(0, 3));
      cycle(($urandom_range(0, 199) == 0), zr, ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 1) == 1));
      check_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
